// File: rtl/mem_port_arbiter.sv
// Shares one single-port, word-addressed memory between the fetch (i_*) and load/store (d_*) ports.
// Latency: grant is combinational in the request cycle; rvalid/rdata are registered one cycle later.
// Backpressure: a denied requester holds its request; a starvation counter forces one fetch grant after MAX_WAIT denials.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt          fetch request and same-cycle grant
//   i_rvalid/i_rdata               fetch response, one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata      load/store request, held until d_gnt
//   d_gnt, d_rvalid/d_rdata        data grant and response (rdata is 0 after a store)
//   mem_we/mem_addr/mem_wr_data    memory write port; memory uses mem_addr[ADDR_W-1:2]
//   mem_rd_data                    memory combinational read data
//   stat_conflicts                 saturating count of cycles with both requests active
//
// Build option: define ARB_STATS_EN to implement stat_conflicts; otherwise it is tied to 0.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       stat_conflicts
);

  typedef enum logic {
    PRIO_D = 1'b0,
    PRIO_I = 1'b1
  } state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_nxt;
  logic        w_i_gnt;
  logic        w_d_gnt;

  logic              r_i_rvalid;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;

  // Grant, wait counter and priority FSM next state.
  always_comb begin
    w_i_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_wait_nxt  = 4'd0;
    w_state_nxt = r_state;

    if (i_req && d_req) begin
      if (r_state == PRIO_I) w_i_gnt = 1'b1;
      else                   w_d_gnt = 1'b1;
    end else begin
      w_i_gnt = i_req;
      w_d_gnt = d_req;
    end

    // Count consecutive denied fetch cycles; a withdrawn or granted fetch restarts the count.
    if (i_req && !w_i_gnt) begin
      if (r_wait >= LP_MAX_WAIT) w_wait_nxt = LP_MAX_WAIT;
      else                       w_wait_nxt = r_wait + 4'd1;
    end

    case (r_state)
      PRIO_D: if (i_req && !w_i_gnt && (w_wait_nxt == LP_MAX_WAIT)) w_state_nxt = PRIO_I;
      PRIO_I: if (w_i_gnt) w_state_nxt = PRIO_D;
      default: w_state_nxt = PRIO_D;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRIO_D;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Memory side: idle cycles present the fetch address so a fetch can start without a mux change.
  assign mem_addr    = w_d_gnt ? d_addr : i_addr;
  // Gating with rst_n stops a store whose edge has not yet arrived when reset asserts.
  assign mem_we      = w_d_gnt & d_we & rst_n;
  assign mem_wr_data = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_d_rvalid <= w_d_gnt;
      if (w_i_gnt) r_i_rdata <= mem_rd_data;
      if (w_d_gnt) r_d_rdata <= d_we ? '0 : mem_rd_data;
    end
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] r_conflicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflicts <= 16'd0;
    end else if (i_req && d_req && (r_conflicts != 16'hFFFF)) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign stat_conflicts = r_conflicts;
`else
  assign stat_conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single-cycle vectors plus hand-written multi-cycle sequences.
// Grants and memory-side outputs are checked combinationally; read responses go through a scoreboard queue.
// The bench owns the memory model; expected read data comes from the bench memory at the expected address.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic [15:0] stat_conflicts;

  logic        load_mem;
  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dw;
    logic        eig;
    logic        edg;
    logic        ewe;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_gnt          (i_gnt),
    .i_rvalid       (i_rvalid),
    .i_rdata        (i_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data    (mem_rd_data),
    .stat_conflicts (stat_conflicts)
  );

  // Word-addressed memory: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA000_0000 | 32'(k);
      mem[2] <= 32'h00A0_0093;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wr_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: inputs were driven at the preceding negedge. Checks grants, pushes the
  // expected response, then after the edge pops and compares the responses.
  task automatic step(input logic eig, input logic edg, input logic ewe, input logic [31:0] eaddr);
    logic [31:0] rd;
    #1;
    chk("i_gnt", 32'(i_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wr_data", mem_wr_data, d_wdata);
    rd = mem[eaddr[7:2]];
    if (eig) iq.push_back(rd);
    if (edg) dq.push_back(d_we ? 32'h0 : rd);
    @(posedge clk);
    #1;
    chk("i_rvalid", 32'(i_rvalid), 32'(eig));
    chk("d_rvalid", 32'(d_rvalid), 32'(edg));
    if (i_rvalid) begin
      if (iq.size() == 0) chk("i_rdata_unexpected", 32'(i_rvalid), 32'h0);
      else                chk("i_rdata", i_rdata, iq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_rdata_unexpected", 32'(d_rvalid), 32'h0);
      else                chk("d_rdata", d_rdata, dq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs(input logic [31:0] ia);
    i_req  = 1'b0;
    i_addr = ia;
    d_req  = 1'b0;
    d_we   = 1'b0;
    d_addr = 32'h0;
    d_wdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_stat;
`ifdef ARB_STATS_EN
    exp_stat = 16'd6;
`else
    exp_stat = 16'd0;
`endif

    vt[0] = '{1'b1, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 32'h08};
    vt[1] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h0C, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0C};
    vt[2] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 32'h12345678,  1'b0, 1'b1, 1'b1, 32'h14};
    vt[3] = '{1'b1, 32'h04, 1'b1, 1'b0, 32'h18, 32'h0,         1'b0, 1'b1, 1'b0, 32'h18};
    vt[4] = '{1'b1, 32'h00, 1'b1, 1'b1, 32'h1C, 32'hCAFEF00D,  1'b0, 1'b1, 1'b1, 32'h1C};
    vt[5] = '{1'b0, 32'h24, 1'b0, 1'b0, 32'h28, 32'h0,         1'b0, 1'b0, 1'b0, 32'h24};
    vt[6] = '{1'b1, 32'h0B, 1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0B};
    vt[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h0E, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0E};

    // Reset with a store presented: the write enable must stay low.
    rst_n    = 1'b0;
    load_mem = 1'b1;
    idle_inputs(32'h0);
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h20;
    @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_stat", 32'(stat_conflicts), 32'h0);
    @(negedge clk);
    load_mem = 1'b0;
    idle_inputs(32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, each followed by an idle cycle that clears the wait counter.
    for (int v = 0; v < 8; v++) begin
      i_req   = vt[v].ir;
      i_addr  = vt[v].ia;
      d_req   = vt[v].dr;
      d_we    = vt[v].dwe;
      d_addr  = vt[v].da;
      d_wdata = vt[v].dw;
      step(vt[v].eig, vt[v].edg, vt[v].ewe, vt[v].eaddr);
      idle_inputs(32'h3C);
      step(1'b0, 1'b0, 1'b0, 32'h3C);
    end
    chk("store_word5", mem[5], 32'h12345678);
    chk("store_word7", mem[7], 32'hCAFEF00D);

    // Store then load of the same word on consecutive cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    step(1'b0, 1'b1, 1'b1, 32'h10);
    chk("store_ack_rdata", d_rdata, 32'h0);
    d_we = 1'b0; d_wdata = 32'h0;
    step(1'b0, 1'b1, 1'b0, 32'h10);
    chk("raw_rdata", d_rdata, 32'hDEADBEEF);

    // Reset asserted mid-cycle during a granted store, with a load response outstanding.
    d_addr = 32'h0C;
    step(1'b0, 1'b1, 1'b0, 32'h0C);
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55AA55AA;
    #1;
    chk("pre_rst_mem_we", 32'(mem_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_we", 32'(mem_we), 32'h0);
    chk("async_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("async_i_rvalid", 32'(i_rvalid), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_word8", mem[8], 32'hA0000008);
    chk("rst_hold_d_rvalid", 32'(d_rvalid), 32'h0);
    iq.delete();
    dq.delete();
    @(negedge clk);
    idle_inputs(32'h0);
    rst_n = 1'b1;

    // Persistent conflict: four data grants, one forced fetch grant, then data again.
    i_req = 1'b1; i_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h04);
    step(1'b0, 1'b1, 1'b0, 32'h10);
    chk("stat_conflicts", 32'(stat_conflicts), 32'(exp_stat));

    // Withdraw: the denial count restarts after the fetch drops its request.
    i_req = 1'b1; i_addr = 32'h08;
    d_addr = 32'h18;
    for (int c = 0; c < 2; c++) step(1'b0, 1'b1, 1'b0, 32'h18);
    i_req = 1'b0;
    step(1'b0, 1'b1, 1'b0, 32'h18);
    i_req = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'h18);
    step(1'b1, 1'b0, 1'b0, 32'h08);

    // Idle for ten cycles.
    idle_inputs(32'h30);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 32'h30);

    // After idling the counter is clear and data priority is back in force.
    i_req = 1'b1; i_addr = 32'h0C;
    d_req = 1'b1; d_addr = 32'h14;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'h14);
    step(1'b1, 1'b0, 1'b0, 32'h0C);
    idle_inputs(32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-addressed memory (combinational read, write on posedge clk) between the instruction-fetch port and the load/store port of the pipeline.
- Arbitrates once per cycle with a same-cycle grant.
- Returns registered read data one cycle after the grant.
- Guarantees fetch forward progress with a starvation counter.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive denied fetch-request cycles before fetch gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until granted.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  fetch read data valid (registered).
- i_rdata  out  DATA_W  fetch read data (registered).
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata stable until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data port granted this cycle (combinational).
- d_rvalid  out  1  load data valid or store acknowledge (registered).
- d_rdata  out  DATA_W  load data (registered); 0 after a store.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address; memory uses bits [ADDR_W-1:2].
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory combinational read data.
- stat_conflicts  out  16  conflict count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0.
  - FSM in PRIO_D; wait counter 0; stat_conflicts=0.
  - mem_we forced 0 combinationally while rst_n=0.
- FSM states:
  - PRIO_D (default): d_req wins a conflict.
  - PRIO_I: i_req wins a conflict.
- Grant, combinational each cycle:
  - Only one request active: that request is granted.
  - Both active: the state's priority port wins.
  - Neither active: no grant; mem_we=0; mem_addr=i_addr.
- Memory muxing:
  - Granted port drives mem_addr.
  - mem_we = d_gnt & d_we.
  - mem_wr_data = d_wdata always.
- Wait counter:
  - Increments on every cycle with i_req=1 and i_gnt=0; saturates at MAX_WAIT.
  - Clears on any cycle with i_gnt=1 or i_req=0.
- Transitions:
  - PRIO_D -> PRIO_I when the counter would reach MAX_WAIT this cycle.
  - PRIO_I -> PRIO_D after the cycle in which i_gnt=1.
  - PRIO_I lasts exactly until one fetch is granted.
- Response latency is 1 cycle:
  - Edge after i_gnt: i_rvalid=1, i_rdata=mem_rd_data sampled in the grant cycle.
  - Edge after d_gnt with d_we=0: d_rvalid=1, d_rdata=mem_rd_data.
  - Edge after d_gnt with d_we=1: d_rvalid=1, d_rdata=0; memory is written on that same edge.
  - rvalid deasserts on the next edge unless granted again; back-to-back grants give continuous rvalid.
- Read-after-write on consecutive cycles: the load samples memory after the store edge, so it returns the new data.
- Addresses are passed unmodified. Misaligned low bits are ignored by memory; no error is raised.
- Requester withdrawing req before grant: legal. No side effects; the counter clears.
- Reset mid-transaction: pending rvalid is dropped. A write that has not reached its clock edge is not performed.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_conflicts increments (saturating at 16'hFFFF) every cycle with i_req=1 and d_req=1.
  - Cleared by reset.
- Undefined:
  - Counter logic is absent; stat_conflicts tied to 0.
  - Arbitration is identical.

Test Plan:
- Fetch only: i_req=1, i_addr=0x08, memory word 2 = 0x00A00093 -> i_gnt=1 same cycle; next cycle i_rvalid=1, i_rdata=0x00A00093; d_rvalid stays 0.
- Store then load: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF (cycle 0); then d_we=0, d_addr=0x10 (cycle 1) -> cycle 1 d_rvalid=1, d_rdata=0; cycle 2 d_rvalid=1, d_rdata=0xDEADBEEF.
- Conflict: i_req=1 and d_req=1 with d_we=0, both held, MAX_WAIT=4 -> d_gnt cycles 0-3; i_gnt=1 at cycle 4 with d_gnt=0; d_gnt resumes at cycle 5; with ARB_STATS_EN, stat_conflicts=6 after cycle 5.
- Withdraw: i_req high 2 cycles while d_req holds the grant, then i_req=0 for 1 cycle, then high again -> counter restarts from 0; forced fetch grant occurs 4 denied cycles later.
- Async reset: rst_n pulled low mid-cycle while d_gnt=1, d_we=1, d_addr=0x20 -> mem_we drops immediately; word 8 unchanged; all rvalid=0; state PRIO_D after release.
- Idle: no requests for 10 cycles -> no grants, mem_we=0, rvalids 0, counter 0.
